// File: rtl/dff_level_gen.sv
// dff_level_gen: rebuilds a registered do level from rise/fall request pulses.
// do is held high for at least MIN_HIGH cycles and low for at least MIN_LOW cycles after each fall.
// Build option DFF_LEVEL_GEN_PEND_EN: early requests are parked in one-bit pend flags and
// replayed later. Without it, early requests are dropped and reported on o_err.
module dff_level_gen #(
  parameter int MIN_HIGH = 2,
  parameter int MIN_LOW  = 2,
  parameter int CW       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_r,
  input  logic i_f,
  output logic o_do,
  output logic o_busy,
  output logic o_err
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HIGH = 2'd1, S_GAP = 2'd2} state_t;
  localparam logic [CW:0] LP_MIN_HIGH = (CW+1)'(MIN_HIGH);
  localparam logic [CW:0] LP_MIN_LOW  = (CW+1)'(MIN_LOW);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CW:0] w_cnt_inc;
  logic w_high_met, w_low_met;
  logic w_take_r, w_take_f, w_early_r, w_early_f, w_drop, w_err;
  logic r_r_pend, r_f_pend;
  // one extra bit so the dwell test stays correct once the counter has saturated
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_high_met = w_cnt_inc >= LP_MIN_HIGH;
  assign w_low_met  = w_cnt_inc >= LP_MIN_LOW;
  // next state plus classification of each request as taken, early or dropped
  always_comb begin
    w_next    = r_state;
    w_take_r  = 1'b0;
    w_take_f  = 1'b0;
    w_early_r = 1'b0;
    w_early_f = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_take_r  = i_r | r_r_pend;
        w_next    = w_take_r ? S_HIGH : S_IDLE;
        w_early_f = i_f & w_take_r;
        w_drop    = i_f & ~w_take_r;
      end
      S_HIGH: begin
        w_take_f  = (i_f | r_f_pend) & w_high_met;
        w_next    = w_take_f ? S_GAP : S_HIGH;
        w_early_f = i_f & ~w_high_met;
        w_drop    = i_r;
      end
      S_GAP: begin
        w_next    = w_low_met ? S_IDLE : S_GAP;
        w_early_r = i_r;
        w_drop    = i_f;
      end
      default: w_next = S_IDLE;
    endcase
  end
`ifdef DFF_LEVEL_GEN_PEND_EN
  // early requests wait in their flag until the FSM can act on them; repeats are absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r_pend <= 1'b0;
      r_f_pend <= 1'b0;
    end else begin
      r_r_pend <= w_take_r ? 1'b0 : (r_r_pend | w_early_r);
      r_f_pend <= w_take_f ? 1'b0 : (r_f_pend | w_early_f);
    end
  end
  assign w_err = w_drop;
`else
  assign r_r_pend = 1'b0;
  assign r_f_pend = 1'b0;
  assign w_err    = w_drop | w_early_r | w_early_f;
`endif
  // state register, saturating dwell counter and outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      o_do    <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : (&r_cnt ? r_cnt : w_cnt_inc[CW-1:0]);
      o_do    <= w_next == S_HIGH;
      o_busy  <= w_next != S_IDLE;
      o_err   <= w_err;
    end
  end
endmodule

// File: tb/tb_dff_level_gen.sv
// tb_dff_level_gen: timestamp-based reference model checks two instances (2/2 and 1/1 dwell) every cycle
module tb_dff_level_gen;
`ifdef DFF_LEVEL_GEN_PEND_EN
  localparam bit PEND = 1'b1;
  localparam logic [31:0] T3_R = 32'h1, T3_F = 32'h01, T3_DO = 32'h003, T3_BUSY = 32'h00F, T3_ERR = 32'h000;
  localparam logic [31:0] T4_DO = 32'hFC7, T4_BUSY = 32'hFDF, T4_ERR = 32'h000;
`else
  localparam bit PEND = 1'b0;
  localparam logic [31:0] T3_R = 32'h1, T3_F = 32'h11, T3_DO = 32'h00F, T3_BUSY = 32'h03F, T3_ERR = 32'h001;
  localparam logic [31:0] T4_DO = 32'h007, T4_BUSY = 32'h01F, T4_ERR = 32'h010;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r = 1'b0;
  logic f = 1'b0;
  logic [1:0] q_do, q_busy, q_err;
  int errors = 0;
  int checks = 0;
  int e = 0;
  int mh[2] = '{2, 1};
  int ml[2] = '{2, 1};
  bit m_high[2], rp[2], fp[2], x_do[2], x_busy[2], x_err[2];
  int t_rise[2], t_fall[2];
  logic [31:0] h_do, h_busy, h_err;

  dff_level_gen #(.MIN_HIGH(2), .MIN_LOW(2), .CW(8)) d0 (
    .clk(clk), .rst_n(rst_n), .i_r(r), .i_f(f), .o_do(q_do[0]), .o_busy(q_busy[0]), .o_err(q_err[0]));
  dff_level_gen #(.MIN_HIGH(1), .MIN_LOW(1), .CW(8)) d1 (
    .clk(clk), .rst_n(rst_n), .i_r(r), .i_f(f), .o_do(q_do[1]), .o_busy(q_busy[1]), .o_err(q_err[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_high[i] = 0; rp[i] = 0; fp[i] = 0;
      x_do[i] = 0; x_busy[i] = 0; x_err[i] = 0;
      t_rise[i] = 0; t_fall[i] = -100000;
    end
  endtask

  // do is high between a rise and a fall; after a fall the line is busy for MIN_LOW edges
  task automatic model_step(input bit rr, input bit ff);
    for (int i = 0; i < 2; i++) begin
      bit gap, idle, er;
      gap  = !m_high[i] && (e - t_fall[i] <= ml[i]);
      idle = !m_high[i] && !gap;
      er   = 0;
      if (idle) begin
        if (rr || rp[i]) begin
          m_high[i] = 1; t_rise[i] = e; rp[i] = 0;
          if (ff) begin if (PEND) fp[i] = 1; else er = 1; end
        end else if (ff) er = 1;
      end else if (m_high[i]) begin
        if (rr) er = 1;
        if ((ff || fp[i]) && (e - t_rise[i] >= mh[i])) begin
          m_high[i] = 0; t_fall[i] = e; fp[i] = 0;
        end else if (ff) begin
          if (PEND) fp[i] = 1; else er = 1;
        end
      end else begin
        if (ff) er = 1;
        if (rr) begin if (PEND) rp[i] = 1; else er = 1; end
      end
      x_do[i]   = m_high[i];
      x_busy[i] = m_high[i] || (e - t_fall[i] < ml[i]);
      x_err[i]  = er;
    end
    e++;
  endtask

  task automatic cyc(input bit rr, input bit ff);
    @(negedge clk);
    r = rr;
    f = ff;
    model_step(rr, ff);
  endtask

  task automatic do_reset();
    @(negedge clk);
    r = 0;
    f = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rst_do%0d", i), q_do[i], 0);
      chk($sformatf("async_rst_busy%0d", i), q_busy[i], 0);
      chk($sformatf("async_rst_err%0d", i), q_err[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic seq(input logic [31:0] rv, input logic [31:0] fv, input int n);
    h_do = 0; h_busy = 0; h_err = 0;
    for (int i = 0; i <= n; i++) begin
      cyc(i < n ? rv[i] : 1'b0, i < n ? fv[i] : 1'b0);
      if (i > 0) begin
        h_do[i-1] = q_do[0]; h_busy[i-1] = q_busy[0]; h_err[i-1] = q_err[0];
      end
    end
  endtask

  // per-cycle comparison of both instances against the model
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc_do%0d", i), q_do[i], x_do[i]);
      chk($sformatf("cyc_busy%0d", i), q_busy[i], x_busy[i]);
      chk($sformatf("cyc_err%0d", i), q_err[i], x_err[i]);
    end
  end

  initial begin
    int rises, falls, errs;
    logic prev;
    model_reset();
    @(negedge clk);
    chk("rst_do", q_do[0], 0);
    chk("rst_busy", q_busy[0], 0);
    chk("rst_err", q_err[0], 0);
    rst_n = 1'b1;
    cyc(1, 0); cyc(0, 0); cyc(0, 0);
    chk("t1_pre_do", q_do[0], 1);
    do_reset();
    repeat (5) cyc(0, 0);
    chk("t1_idle_do", q_do[0], 0);
    chk("t1_idle_busy", q_busy[0], 0);
    seq(32'h1, 32'h20, 12);
    chk("t2_do", h_do, 32'h01F);
    chk("t2_busy", h_busy, 32'h07F);
    chk("t2_err", h_err, 32'h000);
    do_reset();
    seq(T3_R, T3_F, 12);
    chk("t3_do", h_do, T3_DO);
    chk("t3_busy", h_busy, T3_BUSY);
    chk("t3_err", h_err, T3_ERR);
    do_reset();
    seq(32'h11, 32'h08, 12);
    chk("t4_do", h_do, T4_DO);
    chk("t4_busy", h_busy, T4_BUSY);
    chk("t4_err", h_err, T4_ERR);
    do_reset();
    seq(32'h0C, 32'h41, 12);
    chk("t5_do", h_do, 32'h03C);
    chk("t5_busy", h_busy, 32'h0FC);
    chk("t5_err", h_err, 32'h009);
    do_reset();
    rises = 0; falls = 0; errs = 0;
    prev = q_do[1];
    for (int k = 0; k < 33; k++) begin
      cyc(k < 30 && k % 3 == 0, k < 30 && k % 3 == 1);
      if (q_do[1] && !prev) rises++;
      if (!q_do[1] && prev) falls++;
      if (q_err[1]) errs++;
      prev = q_do[1];
    end
    chk("t6_rises", rises, 10);
    chk("t6_falls", falls, 10);
    chk("t6_errs", errs, 0);
    do_reset();
    cyc(1, 0);
    repeat (300) cyc(0, 0);
    chk("t6_sat_cnt1", d1.r_cnt, 8'd255);
    chk("t6_sat_cnt0", d0.r_cnt, 8'd255);
    chk("t6_sat_do1", q_do[1], 1);
    cyc(0, 1);
    repeat (4) cyc(0, 0);
    chk("t6_end_do1", q_do[1], 0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    repeat (2) cyc(0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
